// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: pixel prescaler, h/v counters, syncs, active video.
// Define VGA_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt is 0.
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif

module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 pixel_tick,
    output logic                 display_on,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [`H_SIZE-1:0]   x_addr,
    output logic [`V_SIZE-1:0]   y_addr,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned H_W     = `H_SIZE;
    localparam int unsigned V_W     = `V_SIZE;
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS    = H_W'(H_DISPLAY);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_DISPLAY + H_FRONT);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS    = V_W'(V_DISPLAY);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_DISPLAY + V_FRONT);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [3:0]     DIV_LAST = 4'(CLK_DIV - 1);

    if (H_TOTAL > (1 << H_W)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in H_SIZE bits");
    end
    if (V_TOTAL > (1 << V_W)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in V_SIZE bits");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end

    logic [3:0]     div_q, div_d;
    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           hs_act, vs_act;

    always_comb begin
        div_d       = div_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        pixel_tick  = (div_q == DIV_LAST);
        line_start  = pixel_tick && (h_cnt_q == H_LAST);
        frame_start = line_start && (v_cnt_q == V_LAST);
        if (pixel_tick) begin
            div_d   = '0;
            h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
            if (line_start) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end
        end else begin
            div_d = div_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            h_cnt_q <= H_LAST;
            v_cnt_q <= V_LAST;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Sync and video flags decode straight from the counters: zero added latency.
    always_comb begin
        hs_act     = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        vs_act     = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        display_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        vga_hsync  = hs_act ? SYNC_POL : ~SYNC_POL;
        vga_vsync  = vs_act ? SYNC_POL : ~SYNC_POL;
        x_addr     = h_cnt_q;
        y_addr     = v_cnt_q;
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 line checks plus reduced-geometry frame checks.
// Small instances use 30x16 totals so whole frames fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic        d_tick, d_de, d_hs, d_vs, d_ls, d_fs;
    logic [9:0]  d_x, d_y;
    logic [15:0] d_fc;

    logic        a_tick, a_de, a_hs, a_vs, a_ls, a_fs;
    logic [9:0]  a_x, a_y;
    logic [15:0] a_fc;

    logic        b_tick, b_de, b_hs, b_vs, b_ls, b_fs;
    logic [9:0]  b_x, b_y;
    logic [15:0] b_fc;

    vga_timing_gen u_d0 (
        .clk(clk), .rst(rst), .pixel_tick(d_tick), .display_on(d_de),
        .vga_hsync(d_hs), .vga_vsync(d_vs), .x_addr(d_x), .y_addr(d_y),
        .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(1), .V_BACK(3), .SYNC_POL(1'b0)
    ) u_s1 (
        .clk(clk), .rst(rst_s), .pixel_tick(a_tick), .display_on(a_de),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .x_addr(a_x), .y_addr(a_y),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(1), .V_BACK(3), .SYNC_POL(1'b1)
    ) u_s2 (
        .clk(clk), .rst(rst_s), .pixel_tick(b_tick), .display_on(b_de),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .x_addr(b_x), .y_addr(b_y),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cnt, hs_first, hs_last, ls_cnt, ls_prev, ls_per;
        int de_cnt, vs_low, fs_cnt;
        int a_fs_n, a_fs_prev, a_fs_per, a_de_n, a_vs_n;
        int b_fs_n, b_fs_first, b_fs_prev, b_fs_per, b_vs_n, b_tick_n;
        bit found;

        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        check("rst_x", d_x, 799);
        check("rst_y", d_y, 524);
        check("rst_de", d_de, 0);
        check("rst_hs", d_hs, 1);
        check("rst_vs", d_vs, 1);
        check("rst_tick", d_tick, 1);
        check("rst_ls", d_ls, 1);
        check("rst_fs", d_fs, 1);
        check("rst_fc", d_fc, 0);
        check("rst_s1_fs", a_fs, 1);
        check("rst_s2_tick", b_tick, 0);
        check("rst_s2_fs", b_fs, 0);
        check("rst_s2_hs", b_hs, 0);
        check("rst_s2_vs", b_vs, 0);

        rst = 1'b0;
        check("rel_fs", d_fs, 1);
        @(negedge clk);
        check("first_x", d_x, 0);
        check("first_y", d_y, 0);
        check("first_de", d_de, 1);
        check("first_fs", d_fs, 0);

        hs_cnt = 0; hs_first = -1; hs_last = -1;
        ls_cnt = 0; ls_prev = -1; ls_per = 0;
        de_cnt = 0; vs_low = 0; fs_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            if (i == 639) begin
                check("x639", d_x, 639);
                check("de639", d_de, 1);
            end
            if (i == 640) begin
                check("x640", d_x, 640);
                check("de640", d_de, 0);
            end
            if (i == 800) begin
                check("line1_x", d_x, 0);
                check("line1_y", d_y, 1);
            end
            if (!d_hs && i < 800) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_x);
                hs_last = int'(d_x);
            end
            if (d_ls) begin
                ls_cnt++;
                if (ls_prev >= 0) ls_per = i - ls_prev;
                ls_prev = i;
            end
            if (d_de) de_cnt++;
            if (!d_vs) vs_low++;
            if (d_fs) fs_cnt++;
            @(negedge clk);
        end
        check("hs_low_cnt", hs_cnt, 96);
        check("hs_first_x", hs_first, 656);
        check("hs_last_x", hs_last, 751);
        check("ls_cnt", ls_cnt, 2);
        check("ls_period", ls_per, 800);
        check("de_2lines", de_cnt, 1280);
        check("vs_line01", vs_low, 0);
        check("fs_none", fs_cnt, 0);

        rst_s = 1'b0;
        a_fs_n = 0; a_fs_prev = -1; a_fs_per = 0; a_de_n = 0; a_vs_n = 0;
        b_fs_n = 0; b_fs_first = -1; b_fs_prev = -1; b_fs_per = 0;
        b_vs_n = 0; b_tick_n = 0;
        for (int c = 0; c < 1930; c++) begin
            if (c == 0) check("s2_tick_c0", b_tick, 0);
            if (c == 1) begin
                check("s2_tick_c1", b_tick, 1);
                check("s2_fs_c1", b_fs, 1);
            end
            if (c == 3) check("s2_hold_x0", b_x, 0);
            if (c == 4) check("s2_step_x1", b_x, 1);
            if (a_fs) begin
                if (a_fs_n == 0) check("s1_fs_first", c, 0);
                check($sformatf("s1_fc_%0d", a_fs_n), a_fc,
                      FC_EN ? a_fs_n : 0);
                if (a_fs_prev >= 0) a_fs_per = c - a_fs_prev;
                a_fs_prev = c;
                a_fs_n++;
            end
            if (c >= 1 && c <= 480) begin
                if (a_de) a_de_n++;
                if (!a_vs) a_vs_n++;
            end
            if (b_fs) begin
                if (b_fs_first < 0) b_fs_first = c;
                if (b_fs_prev >= 0) b_fs_per = c - b_fs_prev;
                b_fs_prev = c;
                b_fs_n++;
            end
            if (c >= 2 && c <= 961 && b_vs) b_vs_n++;
            if (b_tick) b_tick_n++;
            @(negedge clk);
        end
        check("s1_fs_cnt", a_fs_n, 5);
        check("s1_fs_period", a_fs_per, 480);
        check("s1_de_frame", a_de_n, 200);
        check("s1_vs_low", a_vs_n, 30);
        check("s2_fs_cnt", b_fs_n, 3);
        check("s2_fs_first", b_fs_first, 1);
        check("s2_fs_period", b_fs_per, 960);
        check("s2_vs_high", b_vs_n, 60);
        check("s2_tick_cnt", b_tick_n, 965);

        found = 1'b0;
        for (int w = 0; w < 600 && !found; w++) begin
            if (a_x == 10 && a_y == 5) found = 1'b1;
            else @(negedge clk);
        end
        check("s1_find_pos", found, 1);
        check("s1_mid_de", a_de, 1);
        rst_s = 1'b1;
        @(negedge clk);
        check("mid_rst_x", a_x, 29);
        check("mid_rst_y", a_y, 15);
        check("mid_rst_hs", a_hs, 1);
        check("mid_rst_vs", a_vs, 1);
        check("mid_rst_de", a_de, 0);
        check("mid_rst_fc", a_fc, 0);
        check("mid_rst_s2_x", b_x, 29);
        rst_s = 1'b0;
        check("resume_fs", a_fs, 1);
        @(negedge clk);
        check("resume_x", a_x, 0);
        check("resume_y", a_y, 0);
        check("resume_de", a_de, 1);
        check("resume_fc", a_fc, FC_EN ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
